alu_operand_arbiter: RTL and testbench
======================================

Name: alu_operand_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit 8:1 operand mux among eight requesters feeding the ALU.
- Selects one requesting source per transfer and drives the mux select from the arbitration result.
- Registers the selected word into a single-entry output buffer with a valid/ready handshake toward the ALU operand port.
- Supports a per-requester lock so a source can hold priority for multi-word bursts.

Parameters:
- WIDTH, 32, data width of every input word and the output word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  req[i] high: requester i holds a valid word on in_i.
- lock  input  8  lock[i] sampled only at a grant to i; keeps i at top priority for the next arbitration.
- in0..in7  input  WIDTH each  requester data words.
- gnt  output  8  one-hot, one-cycle pulse; gnt[i] means in_i was captured this edge and requester i may drop or advance its word.
- sel  output  3  combinational mux select, equal to the index of the current arbitration winner.
- out_data  output  WIDTH  registered selected word.
- out_src  output  3  registered index of the source of out_data.
- out_valid  output  1  out_data/out_src hold an unconsumed word.
- out_ready  input  1  ALU accepts the word when out_valid && out_ready at a rising edge.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_src=0, gnt=0.
  - Priority pointer last=7, so requester 0 has top priority first.
  - lock_hold=0.
  - Takes effect immediately, including mid-transfer; any held word is discarded.
- Buffer free condition: free = !out_valid || out_ready.
- Arbitration (combinational, every cycle):
  - Base index = last when lock_hold=1, otherwise (last+1) mod 8.
  - Scan upward from the base index with wrap-around; the first i with req[i]=1 wins.
  - sel = winner index. When no req is high, sel = base index.
  - The datapath is an 8:1 WIDTH-bit mux driven by sel.
- Capture at a rising edge when free && |req:
  - out_data <= mux(sel); out_src <= sel; out_valid <= 1.
  - gnt[sel]=1 for exactly that cycle (gnt is combinational = onehot(sel) & {8{free && |req}}).
  - last <= sel; lock_hold <= lock[sel].
- Accept with no new request (free && !|req && out_valid && out_ready): out_valid <= 0; last and lock_hold unchanged.
- Stall (out_valid && !out_ready):
  - gnt=0; out_data, out_src and out_valid hold.
  - Pointer frozen; requesters keep req asserted.
- Latency and throughput:
  - Latency is 1 cycle from req to out_valid when the buffer is empty.
  - Back-to-back: accepting and capturing in the same edge gives full throughput with no bubble.
- Lock behaviour:
  - A locked winner that drops req loses priority naturally: the scan continues from index last.
  - lock_hold clears when a grant is made with lock[sel]=0.
- Fairness: with no locks, every continuously requesting source is granted within 8 grants.
- req is observed at the edge only; a requester deasserting req without a gnt is legal (abandoned request).

Test Plan:
- Reset, then req=8'h01, in0=32'hDEADBEEF, out_ready=1 -> gnt=8'h01 in cycle 0; next cycle out_valid=1, out_data=DEADBEEF, out_src=0.
- req=8'hFF held with distinct data per in_i, out_ready=1, no locks -> grant order 0,1,...,7,0 on consecutive cycles; out_valid continuously 1 with no bubble.
- out_valid=1 and out_ready=0 for 5 cycles while req=8'h0C -> gnt=0 and out_data stable for all 5 cycles; on the first cycle with out_ready=1, gnt=8'h04 (pointer after 2, or 3 depending on last).
  - Directed form: preload last=1 via a prior grant to 1, which then gives gnt=8'h04.
- lock[5]=1 with req=8'h21 after a grant to 5 -> next grant is 5 again; drop lock[5] -> the following grant is 0 (wrap); the grant after that is 5.
- Reset asserted mid-stall with out_valid=1 -> out_valid, gnt and out_data drop to 0 immediately; after release with req=8'h80 -> grant to 7 on the first edge, since 0 through 6 are idle and the scan wraps from 0.
- Accept with req=0 -> out_valid falls next edge; a subsequent single req=8'h10 -> gnt=8'h10 and out_src=4.

Source files
------------

// File: rtl/alu_operand_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_operand_arbiter_if
// Bundles the requester side (req/lock/in0..in7) and the ALU operand port
// (out_data/out_src/out_valid/out_ready) of the operand arbiter.
//   master : requesters + ALU (drive req, lock, in0..in7, out_ready)
//   slave  : the arbiter      (drives gnt, sel, out_data, out_src, out_valid)
// ----------------------------------------------------------------------------
interface alu_operand_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       req;
    logic [7:0]       lock;
    logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic [7:0]       gnt;
    logic [2:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_src;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output req, lock, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        input  gnt, sel, out_data, out_src, out_valid
    );

    modport slave (
        input  req, lock, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        output gnt, sel, out_data, out_src, out_valid
    );
endinterface

// File: rtl/alu_operand_arbiter.sv
// ----------------------------------------------------------------------------
// alu_operand_arbiter
// Round-robin arbiter sharing one WIDTH-bit 8:1 operand mux among eight
// requesters. The winner's word is captured into a single-entry output buffer
// handed to the ALU with a valid/ready handshake. A requester may assert
// lock at its grant to keep top priority for the next arbitration (bursts).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : alu_operand_arbiter_if.slave (req, lock, in0..in7, gnt, sel,
//          out_data, out_src, out_valid, out_ready)
// ----------------------------------------------------------------------------
module alu_operand_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_operand_arbiter_if.slave  bus
);

    // Priority pointer and burst lock
    logic [2:0]       last_q, last_d;
    logic             lock_hold_q, lock_hold_d;
    // Output buffer
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]       out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;

    logic [2:0]       base_idx;
    logic [2:0]       scan_idx;
    logic [2:0]       sel_c;
    logic             found;
    logic             free;
    logic             capture;
    logic [WIDTH-1:0] words [8];

    assign words[0] = bus.in0;
    assign words[1] = bus.in1;
    assign words[2] = bus.in2;
    assign words[3] = bus.in3;
    assign words[4] = bus.in4;
    assign words[5] = bus.in5;
    assign words[6] = bus.in6;
    assign words[7] = bus.in7;

    // A locked owner restarts the scan at itself; otherwise the scan starts
    // one past the last winner. If the owner dropped req, the scan simply
    // moves on, so a lock never blocks other requesters.
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        base_idx = lock_hold_q ? last_q : last_q + 3'd1;
        sel_c    = base_idx;
        scan_idx = base_idx;
        found    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            scan_idx = base_idx + 3'(k);
            if (!found && bus.req[scan_idx]) begin
                sel_c = scan_idx;
                found = 1'b1;
            end
        end
    end

    // The buffer can take a word when empty or being drained this edge,
    // which gives back-to-back captures with no bubble.
    assign free    = !out_valid_q || bus.out_ready;
    assign capture = free && (|bus.req);

    always_comb begin
        last_d      = last_q;
        lock_hold_d = lock_hold_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            out_data_d  = words[sel_c];
            out_src_d   = sel_c;
            out_valid_d = 1'b1;
            last_d      = sel_c;
            lock_hold_d = bus.lock[sel_c];
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= 3'd7;
            lock_hold_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            lock_hold_q <= lock_hold_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sel       = sel_c;
    // gnt is forced low during reset: the emptied buffer would otherwise
    // look free and pulse a grant that no edge will capture.
    assign bus.gnt       = (capture && !rst) ? (8'b1 << sel_c) : 8'b0;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_operand_arbiter
// Directed bench for alu_operand_arbiter. Each step drives req/lock/out_ready
// at the falling edge together with the grant the step is expected to produce;
// the granted source and its word are pushed to a scoreboard queue and popped
// when the ALU side accepts the buffered word.
// ----------------------------------------------------------------------------
module tb_alu_operand_arbiter;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic [2:0]       src;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic m_valid;
    exp_t sb[$];
    logic [WIDTH-1:0] in_words [8];

    alu_operand_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_operand_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_words();
        bus.in0 = in_words[0];
        bus.in1 = in_words[1];
        bus.in2 = in_words[2];
        bus.in3 = in_words[3];
        bus.in4 = in_words[4];
        bus.in5 = in_words[5];
        bus.in6 = in_words[6];
        bus.in7 = in_words[7];
    endtask

    // One cycle: drive, check combinational grant and the buffered word,
    // update the scoreboard, then advance to the next falling edge.
    task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rdy,
                        input logic [7:0] exp_gnt, input string tag);
        int   gi;
        logic free;
        bus.req       = r;
        bus.lock      = l;
        bus.out_ready = rdy;
        #1;
        check({tag, " gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        gi = -1;
        for (int k = 0; k < 8; k++) if (exp_gnt[k]) gi = k;
        if (gi >= 0) check({tag, " sel"}, 32'(bus.sel), 32'(gi));
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
            end else begin
                check({tag, " out_src"}, 32'(bus.out_src), 32'(sb[0].src));
                check({tag, " out_data"}, bus.out_data, sb[0].data);
            end
        end
        free = !m_valid || rdy;
        if (m_valid && rdy && sb.size() > 0) void'(sb.pop_front());
        if (gi >= 0) begin
            sb.push_back('{src: gi[2:0], data: in_words[gi]});
            m_valid = 1'b1;
        end else if (free) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_valid  = 1'b0;
        for (int i = 0; i < 8; i++) in_words[i] = 32'hA5A5_0000 + 32'(i * 32'h1111);
        in_words[0] = 32'hDEADBEEF;
        load_words();
        bus.req       = 8'h00;
        bus.lock      = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset out_src", 32'(bus.out_src), 32'd0);
        check("reset gnt", 32'(bus.gnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request from 0, then drain
        step(8'h01, 8'h00, 1'b1, 8'h01, "single0");
        step(8'h00, 8'h00, 1'b1, 8'h00, "single0_out");

        // All requesting: round-robin 1..7,0,1 back-to-back (last was 0)
        step(8'hFF, 8'h00, 1'b1, 8'h02, "rr1");
        step(8'hFF, 8'h00, 1'b1, 8'h04, "rr2");
        step(8'hFF, 8'h00, 1'b1, 8'h08, "rr3");
        step(8'hFF, 8'h00, 1'b1, 8'h10, "rr4");
        step(8'hFF, 8'h00, 1'b1, 8'h20, "rr5");
        step(8'hFF, 8'h00, 1'b1, 8'h40, "rr6");
        step(8'hFF, 8'h00, 1'b1, 8'h80, "rr7");
        step(8'hFF, 8'h00, 1'b1, 8'h01, "rr0");
        step(8'hFF, 8'h00, 1'b1, 8'h02, "rr1b");

        // Stall with the word from 1 held, then release: winner is 2
        for (int c = 0; c < 5; c++) step(8'h0C, 8'h00, 1'b0, 8'h00, "stall");
        step(8'h0C, 8'h00, 1'b1, 8'h04, "stall_release");

        // Lock burst on 5, lock dropped, then wrap to 0 and back to 5
        step(8'h21, 8'h20, 1'b1, 8'h20, "lock_first");
        step(8'h21, 8'h00, 1'b1, 8'h20, "lock_hold");
        step(8'h21, 8'h00, 1'b1, 8'h01, "lock_wrap0");
        step(8'h21, 8'h00, 1'b1, 8'h20, "lock_back5");

        // Reset during a stall with a held word
        step(8'h0C, 8'h00, 1'b0, 8'h00, "pre_reset_stall");
        bus.req       = 8'h0C;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset out_data", bus.out_data, 32'd0);
        check("midreset out_src", 32'(bus.out_src), 32'd0);
        check("midreset gnt", 32'(bus.gnt), 32'd0);
        sb.delete();
        m_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(8'h80, 8'h00, 1'b1, 8'h80, "post_reset7");

        // Accept with no request, then a single request from 4
        step(8'h00, 8'h00, 1'b1, 8'h00, "accept_idle");
        step(8'h00, 8'h00, 1'b1, 8'h00, "empty");
        step(8'h10, 8'h00, 1'b1, 8'h10, "single4");
        step(8'h00, 8'h00, 1'b1, 8'h00, "single4_out");
        step(8'h00, 8'h00, 1'b1, 8'h00, "final_empty");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
